// File: rtl/tt_um_priority_decoder.sv
// rtl/tt_um_priority_decoder.sv - command-driven 4-to-16 decoder tile with sweep and pulse modes
// Strobe is synchronised, edge-detected, and fires one command that updates a registered 16-bit vector.
module tt_um_priority_decoder #(
  parameter int SYNC_STAGES = 2,
  parameter int PULSE_LEN   = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    PULSE = 2'd2
  } state_t;

  localparam logic [7:0] PULSE_LOAD = 8'(PULSE_LEN - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   fire;
  state_t                 state_q, state_d;
  logic [15:0]            vector_q, vector_d;
  logic [7:0]             cnt_q, cnt_d;
  logic [15:0]            one_hot;
  logic [2:0]             opcode;
  logic [3:0]             idx;
  logic                   unused;

  assign unused  = &{1'b0, uio_in};
  assign opcode  = ui_in[6:4];
  assign idx     = ui_in[3:0];
  assign one_hot = 16'h0001 << idx;

  // The chain and history keep shifting while disabled so re-enabling never sees a stale edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], ui_in[7]};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign fire = ena & sync_q[SYNC_STAGES-1] & ~hist_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      vector_q <= 16'h0000;
      cnt_q    <= 8'h00;
    end else begin
      state_q  <= state_d;
      vector_q <= vector_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    vector_d = vector_q;
    cnt_d    = cnt_q;
    if (fire) begin
      // A command always overrides the running mode and acts on the unshifted vector.
      state_d = IDLE;
      case (opcode)
        3'b000: vector_d = one_hot;
        3'b001: vector_d = vector_q | one_hot;
        3'b010: vector_d = vector_q & ~one_hot;
        3'b011: vector_d = vector_q ^ one_hot;
        3'b100: vector_d = 16'h0000;
        3'b101: begin
          vector_d = one_hot;
          state_d  = (&idx) ? IDLE : SWEEP;
        end
        3'b110: begin
          vector_d = one_hot;
          cnt_d    = PULSE_LOAD;
          state_d  = PULSE;
        end
        default: ;
      endcase
    end else if (ena) begin
      case (state_q)
        SWEEP: begin
          vector_d = vector_q << 1;
          if (vector_q[14] || (vector_q[14:0] == 15'h0000)) begin
            state_d = IDLE;
          end
        end
        PULSE: begin
          if (cnt_q == 8'h00) begin
            vector_d = 16'h0000;
            state_d  = IDLE;
          end else begin
            cnt_d = cnt_q - 8'h01;
          end
        end
        IDLE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    uo_out  = ena ? vector_q[15:8] : 8'h00;
    uio_out = ena ? vector_q[7:0]  : 8'h00;
    uio_oe  = 8'hFF;
  end

endmodule
